// File: rtl/mem_if_mar_mdr.sv
// mem_if_mar_mdr: LC-3 MAR/MDR register pair with a fixed-latency SRAM access FSM.
// Optional feature macro: MAR_AUTOINC_EN (adds MAR_inc post-increment of MAR while idle).
module mem_if_mar_mdr #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Bus,
    input  logic              LD_MAR,
    input  logic              LD_MDR,
    input  logic              Mem_start,
    input  logic              Mem_rw,
`ifdef MAR_AUTOINC_EN
    input  logic              MAR_inc,
`endif
    input  logic [DATA_W-1:0] Mem_rdata,
    output logic [ADDR_W-1:0] MAR_out,
    output logic [DATA_W-1:0] MDR_out,
    output logic              Mem_ce_n,
    output logic              Mem_oe_n,
    output logic              Mem_we_n,
    output logic              Busy,
    output logic              R
);

    // The wait counter is only 4 bits, so the strobe hold time must fit 1..15.
    generate
        if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : gBadWaitCycles
            $error("mem_if_mar_mdr: WAIT_CYCLES must be within 1..15");
        end
    endgenerate

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mar_q, mar_d;
    logic [DATA_W-1:0]   mdr_q, mdr_d;

    // State register; reset drops any access in flight so the strobes release at once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start only from IDLE, hold strobes for WAIT_CYCLES, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Mem_start) begin
                    state_d = Mem_rw ? WR_WAIT : RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            WR_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: bus loads only while idle, MDR captures read data on the last wait cycle.
    always_comb begin
        cnt_d = cnt_q;
        mar_d = mar_q;
        mdr_d = mdr_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (LD_MAR) begin
                    mar_d = Bus[ADDR_W-1:0];
                end
`ifdef MAR_AUTOINC_EN
                else if (MAR_inc) begin
                    mar_d = mar_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
`endif
                if (LD_MDR) begin
                    mdr_d = Bus;
                end
            end
            RD_WAIT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    mdr_d = Mem_rdata;
                end
            end
            WR_WAIT: begin
                cnt_d = cnt_q + 4'd1;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    // Datapath registers for MAR, MDR and the wait counter.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt_q <= 4'd0;
            mar_q <= '0;
            mdr_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
        end
    end

    // Outputs decoded purely from registered state, so OE and WE can never overlap.
    always_comb begin
        Mem_ce_n = 1'b1;
        Mem_oe_n = 1'b1;
        Mem_we_n = 1'b1;
        Busy     = 1'b1;
        R        = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = 1'b0;
            end
            RD_WAIT: begin
                Mem_ce_n = 1'b0;
                Mem_oe_n = 1'b0;
            end
            WR_WAIT: begin
                Mem_ce_n = 1'b0;
                Mem_we_n = 1'b0;
            end
            DONE: begin
                R = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

    assign MAR_out = mar_q;
    assign MDR_out = mdr_q;

endmodule

// File: tb/tb_mem_if_mar_mdr.sv
// tb_mem_if_mar_mdr: directed table, reset/auto-increment sequences and a randomized run
// against a cycle-count transaction model of mem_if_mar_mdr.
module tb_mem_if_mar_mdr;

    localparam int DW = 16;
    localparam int AW = 16;
    localparam int W  = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [DW-1:0] Bus;
    logic          LD_MAR, LD_MDR, Mem_start, Mem_rw;
    logic [DW-1:0] Mem_rdata;
    logic [AW-1:0] MAR_out;
    logic [DW-1:0] MDR_out;
    logic          Mem_ce_n, Mem_oe_n, Mem_we_n, Busy, R;
`ifdef MAR_AUTOINC_EN
    logic          MAR_inc;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Free-running clock, period 10.
    always #5 Clk = ~Clk;

    mem_if_mar_mdr #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .Clk(Clk), .Reset(Reset), .Bus(Bus), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
        .Mem_start(Mem_start), .Mem_rw(Mem_rw),
`ifdef MAR_AUTOINC_EN
        .MAR_inc(MAR_inc),
`endif
        .Mem_rdata(Mem_rdata), .MAR_out(MAR_out), .MDR_out(MDR_out),
        .Mem_ce_n(Mem_ce_n), .Mem_oe_n(Mem_oe_n), .Mem_we_n(Mem_we_n),
        .Busy(Busy), .R(R)
    );

    typedef struct {
        logic        ldMar, ldMdr, start, rw;
        logic [15:0] bus, rdata;
        logic [15:0] expMar, expMdr;
        logic        expBusy, expR, expCe, expOe, expWe;
    } vec_t;

    vec_t vecs[$];

    // Transaction-level model: cycles elapsed since the accepted start (0 = idle).
    int          mElapsed;
    logic        mIsWrite;
    logic [15:0] mMar, mMdr;

    function automatic vec_t mk(logic lm, logic ld, logic st, logic rw, logic [15:0] b, logic [15:0] rd,
                                logic [15:0] em, logic [15:0] ed, logic eb, logic er,
                                logic ec, logic eo, logic ew);
        vec_t v;
        v.ldMar = lm; v.ldMdr = ld; v.start = st; v.rw = rw; v.bus = b; v.rdata = rd;
        v.expMar = em; v.expMdr = ed; v.expBusy = eb; v.expR = er;
        v.expCe = ec; v.expOe = eo; v.expWe = ew;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic lm, input logic ld, input logic st, input logic rw,
                                 input logic [15:0] b, input logic [15:0] rd);
        LD_MAR = lm; LD_MDR = ld; Mem_start = st; Mem_rw = rw; Bus = b; Mem_rdata = rd;
    endtask

    task automatic checkAll(input string tag, input logic [15:0] em, input logic [15:0] ed,
                            input logic eb, input logic er, input logic ec, input logic eo, input logic ew);
        checkOutput({tag, ".MAR"}, 32'(MAR_out), 32'(em));
        checkOutput({tag, ".MDR"}, 32'(MDR_out), 32'(ed));
        checkOutput({tag, ".Busy"}, 32'(Busy), 32'(eb));
        checkOutput({tag, ".R"}, 32'(R), 32'(er));
        checkOutput({tag, ".ce_n"}, 32'(Mem_ce_n), 32'(ec));
        checkOutput({tag, ".oe_n"}, 32'(Mem_oe_n), 32'(eo));
        checkOutput({tag, ".we_n"}, 32'(Mem_we_n), 32'(ew));
    endtask

    task automatic doReset();
        Reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
`ifdef MAR_AUTOINC_EN
        MAR_inc = 1'b0;
`endif
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        mElapsed = 0; mIsWrite = 1'b0; mMar = 16'h0; mMdr = 16'h0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelEdge(input logic inc);
        if (mElapsed == 0) begin
            if (LD_MAR) mMar = Bus;
            else if (inc) mMar = mMar + 16'd1;
            if (LD_MDR) mMdr = Bus;
            if (Mem_start) begin
                mElapsed = 1;
                mIsWrite = Mem_rw;
            end
        end else if (mElapsed == W + 1) begin
            mElapsed = 0;
        end else begin
            if (mElapsed == W && !mIsWrite) mMdr = Mem_rdata;
            mElapsed++;
        end
    endtask

    initial begin
        logic strobing;
        logic incBit;
        doReset();
        @(negedge Clk);
        checkAll("reset", 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Directed table: read 0x3000, write 0x1234 with busy-time noise, combined load+write.
        vecs.push_back(mk(1,0,0,0,16'h3000,16'hBEEF, 16'h3000,16'h0000, 0,0,1,1,1));
        vecs.push_back(mk(0,0,1,0,16'h0000,16'hBEEF, 16'h3000,16'h0000, 1,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'hBEEF, 16'h3000,16'h0000, 1,0,0,0,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'hBEEF, 16'h3000,16'hBEEF, 1,1,1,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'h0000, 16'h3000,16'hBEEF, 0,0,1,1,1));
        vecs.push_back(mk(0,1,0,0,16'h1234,16'hDEAD, 16'h3000,16'h1234, 0,0,1,1,1));
        vecs.push_back(mk(0,0,1,1,16'h0000,16'hDEAD, 16'h3000,16'h1234, 1,0,0,1,0));
        vecs.push_back(mk(1,0,1,0,16'h0042,16'hDEAD, 16'h3000,16'h1234, 1,0,0,1,0));
        vecs.push_back(mk(0,1,1,0,16'h0042,16'hDEAD, 16'h3000,16'h1234, 1,1,1,1,1));
        vecs.push_back(mk(1,1,1,0,16'h0042,16'hDEAD, 16'h3000,16'h1234, 0,0,1,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'hDEAD, 16'h3000,16'h1234, 0,0,1,1,1));
        vecs.push_back(mk(1,1,1,1,16'h00FF,16'hDEAD, 16'h00FF,16'h00FF, 1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'hDEAD, 16'h00FF,16'h00FF, 1,0,0,1,0));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'hDEAD, 16'h00FF,16'h00FF, 1,1,1,1,1));
        vecs.push_back(mk(0,0,0,0,16'h0000,16'hDEAD, 16'h00FF,16'h00FF, 0,0,1,1,1));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ldMar, vecs[i].ldMdr, vecs[i].start, vecs[i].rw, vecs[i].bus, vecs[i].rdata);
            @(negedge Clk);
            checkAll($sformatf("vec%0d", i), vecs[i].expMar, vecs[i].expMdr, vecs[i].expBusy,
                     vecs[i].expR, vecs[i].expCe, vecs[i].expOe, vecs[i].expWe);
        end

        // Reset asserted in the middle of a read: strobes release immediately, no capture.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h5555);
        @(negedge Clk);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h5555);
        @(negedge Clk);
        checkOutput("midrst.pre_oe_n", 32'(Mem_oe_n), 32'd0);
        checkOutput("midrst.pre_MDR", 32'(MDR_out), 32'h2222);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h5555);
        Reset = 1'b0;
        #1;
        checkAll("midrst", 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        @(negedge Clk);
        checkOutput("midrst.hold_MDR", 32'(MDR_out), 32'h0);
        Reset = 1'b1;
        @(negedge Clk);
        checkOutput("midrst.after_Busy", 32'(Busy), 32'd0);

`ifdef MAR_AUTOINC_EN
        // Auto-increment wrap and LD_MAR priority.
        MAR_inc = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0);
        @(negedge Clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        MAR_inc = 1'b1;
        @(negedge Clk);
        checkOutput("autoinc.wrap", 32'(MAR_out), 32'h0000);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0);
        @(negedge Clk);
        checkOutput("autoinc.prio", 32'(MAR_out), 32'h0010);
        MAR_inc = 1'b0;
`endif

        // Randomized traffic against the transaction model.
        doReset();
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                          1'($urandom), 16'($urandom), 16'($urandom));
            incBit = 1'b0;
`ifdef MAR_AUTOINC_EN
            MAR_inc = 1'($urandom);
            incBit = MAR_inc;
`endif
            @(posedge Clk);
            modelEdge(incBit);
            @(negedge Clk);
            strobing = (mElapsed >= 1) && (mElapsed <= W);
            checkAll($sformatf("rand%0d", c), mMar, mMdr, mElapsed != 0, mElapsed == W + 1,
                     !strobing, !(strobing && !mIsWrite), !(strobing && mIsWrite));
            checkOutput("rand.oe_we_excl", 32'(Mem_oe_n | Mem_we_n), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
